// File: rtl/lcd1602_pkg.sv
// Shared constants, bus payload type and address helpers for the LCD1602 receiver.
package lcd1602_pkg;

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ROW_LEN = 16;
    localparam int unsigned COL_W   = 4;
    localparam int unsigned ROW_W   = ROW_LEN * DATA_W;

    localparam logic [DATA_W-1:0] SPACE     = 8'h20;
    localparam logic [ADDR_W-1:0] ROW1_BASE = 7'h00;
    localparam logic [ADDR_W-1:0] ROW2_BASE = 7'h40;
    localparam logic [ADDR_W-1:0] ROW1_WRAP = 7'h27;
    localparam logic [ADDR_W-1:0] ROW2_WRAP = 7'h67;
    localparam logic [ROW_W-1:0]  BLANK_ROW = {ROW_LEN{SPACE}};

    // Instruction prefix mask/code pairs, checked from the widest prefix down.
    localparam logic [DATA_W-1:0] MSK_DDRAM = 8'h80, COD_DDRAM = 8'h80;
    localparam logic [DATA_W-1:0] MSK_CGRAM = 8'hC0, COD_CGRAM = 8'h40;
    localparam logic [DATA_W-1:0] MSK_FUNC  = 8'hE0, COD_FUNC  = 8'h20;
    localparam logic [DATA_W-1:0] MSK_SHIFT = 8'hF0, COD_SHIFT = 8'h10;
    localparam logic [DATA_W-1:0] MSK_DISP  = 8'hF8, COD_DISP  = 8'h08;
    localparam logic [DATA_W-1:0] MSK_ENTRY = 8'hFC, COD_ENTRY = 8'h04;
    localparam logic [DATA_W-1:0] MSK_HOME  = 8'hFE, COD_HOME  = 8'h02;
    localparam logic [DATA_W-1:0] MSK_CLEAR = 8'hFF, COD_CLEAR = 8'h01;

    typedef struct packed {
        logic              rs;
        logic              rw;
        logic              e;
        logic [DATA_W-1:0] data;
    } bus_t;

    typedef enum logic [3:0] {
        INS_NOP,
        INS_CLEAR,
        INS_HOME,
        INS_ENTRY,
        INS_DISP,
        INS_SHIFT,
        INS_FUNC,
        INS_CGRAM,
        INS_DDRAM
    } ins_e;

    // Classify an instruction byte by its highest set bit.
    function automatic ins_e decode_ins(input logic [DATA_W-1:0] b);
        ins_e r;
        if      ((b & MSK_DDRAM) == COD_DDRAM) r = INS_DDRAM;
        else if ((b & MSK_CGRAM) == COD_CGRAM) r = INS_CGRAM;
        else if ((b & MSK_FUNC)  == COD_FUNC)  r = INS_FUNC;
        else if ((b & MSK_SHIFT) == COD_SHIFT) r = INS_SHIFT;
        else if ((b & MSK_DISP)  == COD_DISP)  r = INS_DISP;
        else if ((b & MSK_ENTRY) == COD_ENTRY) r = INS_ENTRY;
        else if ((b & MSK_HOME)  == COD_HOME)  r = INS_HOME;
        else if ((b & MSK_CLEAR) == COD_CLEAR) r = INS_CLEAR;
        else                                   r = INS_NOP;
        return r;
    endfunction

    // Visible cells live at 0x00-0x0F and 0x40-0x4F.
    function automatic logic on_screen(input logic [ADDR_W-1:0] a);
        return a[5:4] == 2'b00;
    endfunction

    // Cursor step with the two-line wrap; the unused holes snap to the next row start.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic inc);
        logic [ADDR_W-1:0] n;
        if (a > ROW1_WRAP && a < ROW2_BASE)  n = ROW2_BASE;
        else if (a > ROW2_WRAP)              n = ROW1_BASE;
        else if (inc) begin
            if      (a == ROW1_WRAP)         n = ROW2_BASE;
            else if (a == ROW2_WRAP)         n = ROW1_BASE;
            else                             n = a + ADDR_W'(1);
        end else begin
            if      (a == ROW2_BASE)         n = ROW1_WRAP;
            else if (a == ROW1_BASE)         n = ROW2_WRAP;
            else                             n = a - ADDR_W'(1);
        end
        return n;
    endfunction

    // Column 0 sits in the top byte of a row vector.
    function automatic logic [DATA_W-1:0] get_cell(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        logic [DATA_W-1:0] v;
        v = SPACE;
        for (int c = 0; c < ROW_LEN; c++) begin
            if (col == COL_W'(c)) v = row[ROW_W-1-DATA_W*c -: DATA_W];
        end
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] set_cell(input logic [ROW_W-1:0]  row,
                                                  input logic [COL_W-1:0]  col,
                                                  input logic [DATA_W-1:0] val);
        logic [ROW_W-1:0] r;
        r = row;
        for (int c = 0; c < ROW_LEN; c++) begin
            if (col == COL_W'(c)) r[ROW_W-1-DATA_W*c -: DATA_W] = val;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd1602_rx_sync.sv
// Two-flop synchronizer for the LCD bus plus the enable falling-edge pulse.
// Ports: clk, rst (sync, high); lcd_rs/rw/e/data_in raw bus inputs;
//        rs_s1/rw_s1/e_s1 first stage; rs_s2/rw_s2/data_s2 second stage;
//        fall_c = e fell (combinational from the flops).
module lcd_bus_sync
    import lcd1602_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_rs,
    input  logic        lcd_rw,
    input  logic        lcd_e,
    input  logic [7:0]  lcd_data_in,
    output logic        rs_s1,
    output logic        rw_s1,
    output logic        e_s1,
    output logic        rs_s2,
    output logic        rw_s2,
    output logic [7:0]  data_s2,
    output logic        fall_c
);

    bus_t s1_q, s1_d;
    bus_t s2_q, s2_d;

    always_comb begin
        s1_d = '{rs: lcd_rs, rw: lcd_rw, e: lcd_e, data: lcd_data_in};
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign rs_s1   = s1_q.rs;
    assign rw_s1   = s1_q.rw;
    assign e_s1    = s1_q.e;
    assign rs_s2   = s2_q.rs;
    assign rw_s2   = s2_q.rw;
    assign data_s2 = s2_q.data;
    // Stage 2 still holds the last high sample of e, so its rs/rw/data belong to the commit.
    assign fall_c  = s2_q.e & ~s1_q.e;

endmodule

// File: rtl/lcd1602_rx.sv
// Receive-side LCD1602 model: decodes driver writes into a 2x16 DDRAM shadow,
// answers busy-flag/address and data reads, and exposes both rows.
// Ports: clk, rst (sync, high); lcd_rs/rw/e/data_in from the driver;
//        lcd_data_out/lcd_data_oe read-back; row1_val/row2_val ([127:120] = column 0);
//        busy flag; cmd_err one-cycle pulse when a write or data read is dropped.
module lcd1602_rx
    import lcd1602_pkg::*;
#(
    parameter int unsigned BUSY_CYC     = 2000,
    parameter int unsigned CLR_BUSY_CYC = 82000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic         lcd_e,
    input  logic [7:0]   lcd_data_in,
    output logic [7:0]   lcd_data_out,
    output logic         lcd_data_oe,
    output logic [127:0] row1_val,
    output logic [127:0] row2_val,
    output logic         busy,
    output logic         cmd_err
);

    localparam int unsigned CNT_W = $clog2(CLR_BUSY_CYC + 1);

    logic              rs_s1, rw_s1, e_s1, rs_s2, rw_s2, fall_c;
    logic [DATA_W-1:0] data_s2;

    lcd_bus_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_data_in (lcd_data_in),
        .rs_s1       (rs_s1),
        .rw_s1       (rw_s1),
        .e_s1        (e_s1),
        .rs_s2       (rs_s2),
        .rw_s2       (rw_s2),
        .data_s2     (data_s2),
        .fall_c      (fall_c)
    );

    logic [ROW_W-1:0]  mem1_q, mem1_d, mem2_q, mem2_d;
    logic [ROW_W-1:0]  row1_q, row1_d, row2_q, row2_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              id_q, id_d, disp_q, disp_d, cg_q, cg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d, err_q, err_d, oe_q, oe_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    ins_e              ins;

    // Transaction decode, busy countdown and next-state of all registered outputs.
    always_comb begin
        ins    = decode_ins(data_s2);
        addr_d = addr_q;
        id_d   = id_q;
        disp_d = disp_q;
        cg_d   = cg_q;
        mem1_d = mem1_q;
        mem2_d = mem2_q;
        cnt_d  = busy_q ? cnt_q - CNT_W'(1) : '0;
        err_d  = 1'b0;

        if (fall_c) begin
            if (rw_s2) begin
                // Busy-flag reads are always allowed; data reads advance the cursor.
                if (rs_s2) begin
                    if (busy_q) err_d  = 1'b1;
                    else        addr_d = next_addr(addr_q, id_q);
                end
            end else if (busy_q) begin
                err_d = 1'b1;
            end else if (rs_s2) begin
                if (!cg_q) begin
                    if (on_screen(addr_q)) begin
                        if (addr_q[ADDR_W-1]) mem2_d = set_cell(mem2_q, addr_q[COL_W-1:0], data_s2);
                        else                  mem1_d = set_cell(mem1_q, addr_q[COL_W-1:0], data_s2);
                    end
                    addr_d = next_addr(addr_q, id_q);
                end
                cnt_d = CNT_W'(BUSY_CYC);
            end else begin
                cnt_d = CNT_W'(BUSY_CYC);
                case (ins)
                    INS_CLEAR: begin
                        mem1_d = BLANK_ROW;
                        mem2_d = BLANK_ROW;
                        addr_d = ROW1_BASE;
                        id_d   = 1'b1;
                        cnt_d  = CNT_W'(CLR_BUSY_CYC);
                    end
                    INS_HOME: begin
                        addr_d = ROW1_BASE;
                        cnt_d  = CNT_W'(CLR_BUSY_CYC);
                    end
                    INS_ENTRY: id_d   = data_s2[1];
                    INS_DISP:  disp_d = data_s2[2];
                    INS_SHIFT: begin
                        // Display shift (S=1) is not modelled; only cursor moves.
                        if (!data_s2[3]) addr_d = next_addr(addr_q, data_s2[2]);
                    end
                    INS_FUNC:  ;
                    INS_CGRAM: cg_d = 1'b1;
                    INS_DDRAM: begin
                        addr_d = data_s2[ADDR_W-1:0];
                        cg_d   = 1'b0;
                    end
                    INS_NOP:   cnt_d = '0;
                    default:   ;
                endcase
            end
        end

        busy_d = (cnt_d != '0);
        // Look ahead one stage so the registered oe equals e_s2 & rw_s2.
        oe_d   = e_s1 & rw_s1;

        // Read-back from next-state values so the register tracks current state exactly.
        if (rs_s1) begin
            if (cg_d || !on_screen(addr_d))  dout_d = SPACE;
            else if (addr_d[ADDR_W-1])       dout_d = get_cell(mem2_d, addr_d[COL_W-1:0]);
            else                             dout_d = get_cell(mem1_d, addr_d[COL_W-1:0]);
        end else begin
            dout_d = {busy_d, addr_d};
        end

        row1_d = disp_d ? mem1_d : BLANK_ROW;
        row2_d = disp_d ? mem2_d : BLANK_ROW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem1_q <= BLANK_ROW;
            mem2_q <= BLANK_ROW;
            row1_q <= BLANK_ROW;
            row2_q <= BLANK_ROW;
            addr_q <= ROW1_BASE;
            id_q   <= 1'b1;
            disp_q <= 1'b0;
            cg_q   <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            oe_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            mem1_q <= mem1_d;
            mem2_q <= mem2_d;
            row1_q <= row1_d;
            row2_q <= row2_d;
            addr_q <= addr_d;
            id_q   <= id_d;
            disp_q <= disp_d;
            cg_q   <= cg_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            err_q  <= err_d;
            oe_q   <= oe_d;
            dout_q <= dout_d;
        end
    end

    assign lcd_data_out = dout_q;
    assign lcd_data_oe  = oe_q;
    assign row1_val     = row1_q;
    assign row2_val     = row2_q;
    assign busy         = busy_q;
    assign cmd_err      = err_q;

endmodule

// File: tb/tb_lcd1602_rx.sv
// Bench for lcd1602_rx: directed vector table, hand sequences for busy/clear/reset,
// then random bus traffic checked against a behavioural screen model.
module tb_lcd1602_rx;

    localparam int unsigned BUSY = 40;
    localparam int unsigned CLR  = 164;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic         clk = 1'b0;
    logic         rst;
    logic         lcd_rs, lcd_rw, lcd_e;
    logic [7:0]   lcd_data_in;
    logic [7:0]   lcd_data_out;
    logic         lcd_data_oe;
    logic [127:0] row1_val, row2_val;
    logic         busy, cmd_err;

    lcd1602_rx #(.BUSY_CYC(BUSY), .CLR_BUSY_CYC(CLR)) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .row1_val     (row1_val),
        .row2_val     (row2_val),
        .busy         (busy),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: full 128-byte address space, cursor, flags, busy cycles left.
    logic [7:0] m_mem [128];
    logic [6:0] m_addr;
    logic       m_id, m_disp, m_cg;
    int         m_busy;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (m_busy > 0) m_busy--;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_addr = 7'h00;
        m_id   = 1'b1;
        m_disp = 1'b0;
        m_cg   = 1'b0;
        m_busy = 0;
    endtask

    function automatic logic visible(input logic [6:0] a);
        return (a < 7'd16) || (a >= 7'd64 && a < 7'd80);
    endfunction

    function automatic logic [6:0] m_next(input logic [6:0] a, input logic up);
        if (a >= 7'h28 && a <= 7'h3F) return 7'h40;
        if (a >= 7'h68)               return 7'h00;
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h40) return 7'h27;
        if (a == 7'h00) return 7'h67;
        return a - 7'd1;
    endfunction

    function automatic logic [7:0] m_read();
        if (m_cg || !visible(m_addr)) return 8'h20;
        return m_mem[m_addr];
    endfunction

    task automatic m_commit(input logic rs, input logic rw, input logic [7:0] d,
                            input logic was_busy, output logic exp_err);
        exp_err = 1'b0;
        if (rw) begin
            if (rs) begin
                if (was_busy) exp_err = 1'b1;
                else          m_addr  = m_next(m_addr, m_id);
            end
        end else if (was_busy) begin
            exp_err = 1'b1;
        end else if (rs) begin
            if (!m_cg) begin
                if (visible(m_addr)) m_mem[m_addr] = d;
                m_addr = m_next(m_addr, m_id);
            end
            m_busy = BUSY;
        end else if (d != 8'h00) begin
            m_busy = BUSY;
            if (d >= 8'h80) begin
                m_addr = d[6:0];
                m_cg   = 1'b0;
            end else if (d >= 8'h40) begin
                m_cg = 1'b1;
            end else if (d >= 8'h20) begin
                // function set: nothing to model
            end else if (d >= 8'h10) begin
                if (!d[3]) m_addr = m_next(m_addr, d[2]);
            end else if (d >= 8'h08) begin
                m_disp = d[2];
            end else if (d >= 8'h04) begin
                m_id = d[1];
            end else if (d >= 8'h02) begin
                m_addr = 7'h00;
                m_busy = CLR;
            end else begin
                for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
                m_addr = 7'h00;
                m_id   = 1'b1;
                m_busy = CLR;
            end
        end
    endtask

    task automatic check_rows();
        logic [127:0] e1, e2;
        for (int c = 0; c < 16; c++) begin
            e1[127-8*c -: 8] = m_disp ? m_mem[c]      : 8'h20;
            e2[127-8*c -: 8] = m_disp ? m_mem[64 + c] : 8'h20;
        end
        check("row1", row1_val, e1);
        check("row2", row2_val, e2);
    endtask

    // One bus transaction; ends one cycle after its effects became visible.
    task automatic xact(input logic rs, input logic rw, input logic [7:0] d, output logic [7:0] rd);
        logic       was_busy, exp_err;
        logic [7:0] exp_rd;
        int         h;
        h = int'($urandom_range(2, 4));
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_e = 1'b1;
        step(h);
        rd = lcd_data_out;
        check("oe_during_e", 128'(lcd_data_oe), 128'(rw));
        if (rw) begin
            if (rs) begin
                exp_rd = m_read();
                check("rd_data", 128'(rd), 128'(exp_rd));
            end else begin
                exp_rd = {(m_busy > 0), m_addr};
                check("rd_bf", 128'(rd), 128'(exp_rd));
            end
        end
        lcd_e = 1'b0;
        step(1);
        was_busy = (m_busy > 0);
        step(1);
        m_commit(rs, rw, d, was_busy, exp_err);
        check("cmd_err", 128'(cmd_err), 128'(exp_err));
        check("busy", 128'(busy), 128'(m_busy > 0));
        check("oe_after_fall", 128'(lcd_data_oe), 128'(0));
        check_rows();
        step(1);
        check("cmd_err_one_cycle", 128'(cmd_err), 128'(0));
    endtask

    task automatic idle();
        while (m_busy > 0) step(1);
        check("busy_expired", 128'(busy), 128'(0));
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [6:0] exp_addr;
        string      name;
    } vec_t;

    vec_t       vecs [$];
    logic [7:0] rd, d;
    int         op, cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0; lcd_data_in = 8'h00;
        model_reset();
        step(3);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_err", 128'(cmd_err), 128'(0));
        check("rst_oe", 128'(lcd_data_oe), 128'(0));
        check("rst_dout", 128'(lcd_data_out), 128'(0));
        check("rst_row1", row1_val, BLANK);
        check("rst_row2", row2_val, BLANK);
        rst = 1'b0;
        step(1);

        vecs.push_back('{1'b0, 8'h0C, 7'h00, "disp_on"});
        vecs.push_back('{1'b1, 8'h41, 7'h01, "wr_A"});
        vecs.push_back('{1'b1, 8'h42, 7'h02, "wr_B"});
        vecs.push_back('{1'b0, 8'h00, 7'h02, "nop_00"});
        vecs.push_back('{1'b0, 8'h38, 7'h02, "func_set"});
        vecs.push_back('{1'b0, 8'hC0, 7'h40, "set_c0"});
        vecs.push_back('{1'b1, 8'h5A, 7'h41, "wr_Z"});
        vecs.push_back('{1'b0, 8'hCF, 7'h4F, "set_cf"});
        vecs.push_back('{1'b1, 8'h71, 7'h50, "wr_col15"});
        vecs.push_back('{1'b1, 8'h72, 7'h51, "wr_offscreen"});
        vecs.push_back('{1'b0, 8'h80, 7'h00, "set_80"});
        vecs.push_back('{1'b0, 8'h04, 7'h00, "entry_dec"});
        vecs.push_back('{1'b1, 8'h78, 7'h67, "wr_x_dec_wrap"});
        vecs.push_back('{1'b0, 8'h06, 7'h67, "entry_inc"});
        vecs.push_back('{1'b0, 8'h14, 7'h00, "shift_r_67"});
        vecs.push_back('{1'b0, 8'h10, 7'h67, "shift_l_00"});
        vecs.push_back('{1'b0, 8'hA7, 7'h27, "set_27"});
        vecs.push_back('{1'b0, 8'h14, 7'h40, "shift_r_27"});
        vecs.push_back('{1'b0, 8'h10, 7'h27, "shift_l_40"});
        vecs.push_back('{1'b0, 8'hA8, 7'h28, "set_28_hold"});
        vecs.push_back('{1'b0, 8'h10, 7'h40, "shift_l_28"});
        vecs.push_back('{1'b0, 8'hE8, 7'h68, "set_68_hold"});
        vecs.push_back('{1'b0, 8'h14, 7'h00, "shift_r_68"});
        vecs.push_back('{1'b0, 8'h18, 7'h00, "disp_shift_noop"});
        vecs.push_back('{1'b0, 8'h40, 7'h00, "cgram_mode"});
        vecs.push_back('{1'b1, 8'h63, 7'h00, "wr_cgram_drop"});
        vecs.push_back('{1'b0, 8'h85, 7'h05, "set_85"});
        vecs.push_back('{1'b0, 8'h02, 7'h00, "home"});

        foreach (vecs[i]) begin
            xact(vecs[i].rs, 1'b0, vecs[i].d, rd);
            idle();
            xact(1'b0, 1'b1, 8'h00, rd);
            check(vecs[i].name, 128'(rd), 128'({1'b0, vecs[i].exp_addr}));
        end

        check("row1_AB_x", 128'(row1_val[127:112]), 128'(16'h7842));
        check("row1_rest", 128'(row1_val[111:0]), 128'({14{8'h20}}));
        check("row2_col0", 128'(row2_val[127:120]), 128'(8'h5A));
        check("row2_col15", 128'(row2_val[7:0]), 128'(8'h71));

        // Display off hides the rows but keeps the contents.
        xact(1'b0, 1'b0, 8'h08, rd); idle();
        check("disp_off_row1", row1_val, BLANK);
        xact(1'b0, 1'b0, 8'h0C, rd); idle();
        check("disp_on_restore", 128'(row1_val[127:112]), 128'(16'h7842));

        // Data read from cell 0 advances the cursor.
        xact(1'b0, 1'b0, 8'h80, rd); idle();
        xact(1'b1, 1'b1, 8'h00, rd);
        check("read_cell0", 128'(rd), 128'(8'h78));
        xact(1'b0, 1'b1, 8'h00, rd);
        check("read_advanced", 128'(rd), 128'(8'h01));

        // Busy length after a data write.
        xact(1'b1, 1'b0, 8'h43, rd);
        cnt = 1;
        while (busy === 1'b1 && cnt <= int'(BUSY) + 5) begin cnt++; step(1); end
        check("busy_len_write", 128'(cnt), 128'(BUSY));
        idle();

        // Clear: busy length, then a second clear probed while busy.
        xact(1'b0, 1'b0, 8'h01, rd);
        cnt = 1;
        while (busy === 1'b1 && cnt <= int'(CLR) + 5) begin cnt++; step(1); end
        check("busy_len_clear", 128'(cnt), 128'(CLR));
        idle();
        xact(1'b1, 1'b0, 8'h41, rd); idle();
        xact(1'b0, 1'b0, 8'h01, rd);
        xact(1'b1, 1'b0, 8'h4B, rd);
        check("clear_drop_row1", row1_val, BLANK);
        xact(1'b0, 1'b1, 8'h00, rd);
        check("bf_during_busy", 128'(rd), 128'(8'h80));
        idle();
        xact(1'b0, 1'b1, 8'h00, rd);
        check("bf_after_busy", 128'(rd), 128'(8'h00));

        // Reset mid-busy with e high; e falls while reset is held.
        xact(1'b1, 1'b0, 8'h52, rd);
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data_in = 8'h51; lcd_e = 1'b1; rst = 1'b1;
        step(1);
        model_reset();
        check("rst_mid_busy", 128'(busy), 128'(0));
        check("rst_mid_row1", row1_val, BLANK);
        check("rst_mid_row2", row2_val, BLANK);
        step(2);
        lcd_e = 1'b0;
        step(2);
        rst = 1'b0;
        step(4);
        check("rst_fall_ignored_busy", 128'(busy), 128'(0));
        check("rst_fall_ignored_err", 128'(cmd_err), 128'(0));
        xact(1'b0, 1'b1, 8'h00, rd);
        check("rst_fall_ignored_addr", 128'(rd), 128'(8'h00));

        // Random traffic against the model.
        xact(1'b0, 1'b0, 8'h0C, rd); idle();
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 11));
            case (op)
                0, 1, 2, 3: xact(1'b1, 1'b0, 8'($urandom_range(33, 126)), rd);
                4: begin
                    case ($urandom_range(0, 2))
                        0:       d = 8'h80 | 8'($urandom_range(0, 15));
                        1:       d = 8'hC0 | 8'($urandom_range(0, 15));
                        default: d = 8'h80 | 8'($urandom_range(0, 127));
                    endcase
                    xact(1'b0, 1'b0, d, rd);
                end
                5: xact(1'b0, 1'b0, 8'h04 | 8'($urandom_range(0, 3)), rd);
                6: xact(1'b0, 1'b0, ($urandom_range(0, 3) != 0) ? 8'h0C : 8'h08, rd);
                7: xact(1'b0, 1'b0, 8'h10 | 8'($urandom_range(0, 15)), rd);
                8: xact(1'b0, 1'b0, 8'($urandom_range(0, 127)), rd);
                9: xact(1'b0, 1'b1, 8'h00, rd);
                default: xact(1'b1, 1'b1, 8'h00, rd);
            endcase
            if ($urandom_range(0, 4) != 0) idle();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd1602_rx.md
Name: lcd1602_rx

Overview:
- Receive-side model of the HD44780/LCD1602 bus, the opposite end of our lcd1602 write driver.
- Samples rs/rw/e/data from a driver and decodes instructions and data writes into a 2x16 DDRAM shadow.
- Exposes the shadow as two 128-bit row vectors in the same packing the driver consumes, so screen content can be mirrored (e.g. to VGA) or checked in simulation.
- Answers busy-flag/address and data reads.

Parameters:
- BUSY_CYC, 2000, clk cycles busy after a data write or a normal instruction (about 40 us at 50 MHz).
- CLR_BUSY_CYC, 82000, clk cycles busy after clear display or return home (about 1.64 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- lcd_rs  in  1  register select (0 = instruction, 1 = data)
- lcd_rw  in  1  0 = write, 1 = read
- lcd_e  in  1  enable strobe; a transaction commits on its falling edge
- lcd_data_in  in  8  bus value driven by the initiator
- lcd_data_out  out  8  read-back value
- lcd_data_oe  out  1  high while this block drives the bus
- row1_val  out  128  DDRAM 0x00-0x0F; [127:120] = column 0
- row2_val  out  128  DDRAM 0x40-0x4F; [127:120] = column 0
- busy  out  1  busy flag
- cmd_err  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset (sync, active-high), all fields:
  - every DDRAM cell = 8'h20
  - addr = 7'h00, id = 1, display_on = 0, cgram_mode = 0
  - busy = 0, busy counter = 0
  - lcd_data_out = 0, lcd_data_oe = 0, cmd_err = 0
  - synchronizer flops = 0, so a falling edge of e that straddles reset is not registered
  - reset mid-busy aborts the busy period immediately
- Input sampling:
  - rs, rw, e and data pass through a 2-flop synchronizer.
  - fall = e_s2 & ~e_s1, taken on the synchronized signals.
  - rs, rw and data are captured from the stage aligned with fall.
  - The transaction's effects (state update, busy assertion) are visible on the cycle after fall is detected.
- Instruction write (rs=0, rw=0), decoded by highest set bit:
  - 0000_0001 clear: all cells = 8'h20, addr = 0, id = 1; busy for CLR_BUSY_CYC.
  - 0000_001x return home: addr = 0; busy for CLR_BUSY_CYC.
  - 0000_01IS entry mode: id = I; S ignored (display shift not supported).
  - 0000_1DCB display control: display_on = D; C and B ignored.
  - 0001_SRxx cursor/shift: if S=0, addr moves +1 (R=1) or -1 (R=0) with the wrap rule below; if S=1, no effect.
  - 001x_xxxx function set: accepted, no effect.
  - 01xx_xxxx set CGRAM address: cgram_mode = 1.
  - 1aaa_aaaa set DDRAM address: addr = a, cgram_mode = 0.
  - 0000_0000: ignored, no busy.
  - Every other accepted instruction sets busy for BUSY_CYC.
- Data write (rs=1, rw=0):
  - If cgram_mode, the data is discarded and addr is unchanged.
  - Otherwise the cell is stored only if addr is 0x00-0x0F or 0x40-0x4F (off-screen writes are dropped silently).
  - addr then advances per id.
  - Busy for BUSY_CYC.
- Address wrap:
  - Increment: 0x27 -> 0x40 and 0x67 -> 0x00.
  - Decrement: 0x40 -> 0x27 and 0x00 -> 0x67.
  - A set address in 0x28-0x3F or 0x68-0x7F is held as written; a subsequent increment or decrement from it goes to 0x40 or 0x00 respectively.
- Reads:
  - lcd_data_oe = e_s2 & rw_s2.
  - rs=0: lcd_data_out = {busy, addr}. Always allowed, never an error, no state change.
  - rs=1: lcd_data_out = DDRAM cell at addr, or 8'h20 if off-screen or cgram_mode. On fall, addr advances per id; if busy, it is a cmd_err with no advance.
- Busy:
  - busy = (counter != 0); the counter loads on commit and decrements each clk.
  - A write or data read committing while busy=1 is dropped and pulses cmd_err for exactly one cycle.
- Outputs:
  - row1_val/row2_val are registered.
  - When display_on = 0, both rows read all 8'h20 while the DDRAM contents are retained.

Decomposition:
- Package lcd1602_pkg:
  - instruction prefix masks/codes
  - SPACE = 8'h20
  - row base addresses 7'h00 / 7'h40, row length 16
  - wrap bounds 7'h27 / 7'h67
  - address width 7, row vector width 128
- Sub-module lcd_bus_sync: 2-flop synchronizer for rs/rw/e/data plus the falling-edge pulse.

Test Plan:
- Reset, then display control 8'h0C; write data 'A','B' -> row1_val[127:112] = 16'h4142, rest 8'h20, addr = 0x02, busy high for 2000 cycles after each write.
- Set address 8'hC0, write 'Z' -> row2_val[127:120] = 8'h5A, row1 unchanged; write at addr 0x4F -> column 15 set, addr = 0x50, the next write is off-screen and dropped.
- Entry mode 8'h04 (id = 0) at addr 0x00, write 'x' -> cell 0 = 8'h78, addr = 0x67.
- Clear 8'h01 -> all cells 8'h20, busy held exactly 82000 cycles; a data write during that time -> cmd_err one-cycle pulse, no change.
- BF read (rs=0, rw=1) during busy -> lcd_data_out = {1, addr}, oe only while e is high; after busy expires -> {0, addr}.
- Assert rst mid-busy with e high -> busy = 0 next cycle, rows all 8'h20, and the subsequent e fall is ignored.
